// File: rtl/fixed_point_subtract_scheduler_pkg.sv
// Shared types and the reference subtract function for the round-robin
// fixed-point subtract scheduler.
package fixed_point_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_e;

  typedef struct packed {
    word_t c;
    logic  borrow_out;
    logic  overflow;
  } sub_result_t;

  // A (DATA_W+1)-bit difference exposes the unsigned borrow in its top bit.
  function automatic sub_result_t sub_compute(word_t a, word_t b, logic borrow_in);
    logic [DATA_W:0] diff;
    sub_result_t     res;
    diff           = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, borrow_in};
    res.c          = diff[DATA_W-1:0];
    res.borrow_out = diff[DATA_W];
    res.overflow   = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
    return res;
  endfunction

endpackage

// File: rtl/fixed_point_subtract_scheduler_if.sv
// Request/response bundle between the requesters and the subtract scheduler.
interface fixed_point_subtract_scheduler_if
  import fixed_point_pkg::*;
#(
  parameter int R    = 4,
  parameter int N    = DATA_W,
  parameter int ID_W = $clog2(R)
);
  logic [R-1:0]         req_valid;
  logic [R-1:0]         req_ready;
  logic [R-1:0][N-1:0]  req_a;
  logic [R-1:0][N-1:0]  req_b;
  logic [R-1:0]         req_borrow_in;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [N-1:0]         rsp_c;
  logic                 rsp_borrow_out;
  logic                 rsp_overflow;

  modport master (
    output req_valid, req_a, req_b, req_borrow_in, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_borrow_out, rsp_overflow
  );

  modport slave (
    input  req_valid, req_a, req_b, req_borrow_in, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_borrow_out, rsp_overflow
  );
endinterface

// File: rtl/fixed_point_subtract_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting index at or
// above rr_ptr, wrapping around to 0.
module rr_arbiter #(
  parameter int R    = 4,
  parameter int ID_W = $clog2(R)
) (
  input  logic [R-1:0]    req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [R-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any_req
);
  logic [ID_W-1:0] idx [R];
  logic [R-1:0]    rot_req;

  // rot_req[gi] is the request sitting gi positions after the pointer.
  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_rot
      logic [ID_W:0] sum;
      assign sum         = {1'b0, rr_ptr} + (ID_W+1)'(gi);
      assign idx[gi]     = (sum >= (ID_W+1)'(R)) ? ID_W'(sum - (ID_W+1)'(R)) : ID_W'(sum);
      assign rot_req[gi] = req[idx[gi]];
    end
  endgenerate

  assign any_req = |req;

  always_comb begin
    logic found;
    found    = 1'b0;
    grant_id = '0;
    for (int i = 0; i < R; i++) begin
      if (!found && rot_req[i]) begin
        found    = 1'b1;
        grant_id = idx[i];
      end
    end
    grant = any_req ? (R'(1) << grant_id) : '0;
  end
endmodule

// File: rtl/fixed_point_subtract_scheduler.sv
// Shares one fixed-point subtractor between R requesters: IDLE grants,
// EXEC computes, RESP holds the tagged result until it is consumed.
module fixed_point_subtract_scheduler
  import fixed_point_pkg::*;
#(
  parameter int N    = DATA_W,
  parameter int R    = 4,
  parameter int ID_W = $clog2(R)
) (
  input  logic                              clk,
  input  logic                              rst,
  fixed_point_subtract_scheduler_if.slave   sched,
  output logic                              busy
);
  sched_state_e    state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg, ptr_next;
  logic [ID_W-1:0] op_id_reg, rsp_id_reg;
  logic [N-1:0]    a_reg, b_reg;
  logic            borrow_in_reg;
  sub_result_t     result_reg;

  logic [R-1:0]    arb_grant, req_ready_next;
  logic [ID_W-1:0] arb_id;
  logic            arb_any;

  rr_arbiter #(.R(R), .ID_W(ID_W)) u_arb (
    .req      (sched.req_valid),
    .rr_ptr   (rr_ptr_reg),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any_req  (arb_any)
  );

  assign ptr_next = (op_id_reg == ID_W'(R-1)) ? '0 : op_id_reg + ID_W'(1);

  always_comb begin
    state_next     = state_reg;
    req_ready_next = '0;
    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          req_ready_next = arb_grant;
          state_next     = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (sched.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      op_id_reg     <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      borrow_in_reg <= 1'b0;
      result_reg    <= '0;
      rsp_id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && arb_any) begin
        op_id_reg     <= arb_id;
        a_reg         <= sched.req_a[arb_id];
        b_reg         <= sched.req_b[arb_id];
        borrow_in_reg <= sched.req_borrow_in[arb_id];
      end
      if (state_reg == EXEC) begin
        result_reg <= sub_compute(a_reg, b_reg, borrow_in_reg);
        rsp_id_reg <= op_id_reg;
      end
      // Pointer only advances once the consumer has taken the result.
      if (state_reg == RESP && sched.rsp_ready) begin
        rr_ptr_reg <= ptr_next;
      end
    end
  end

  assign sched.req_ready      = req_ready_next;
  assign sched.rsp_valid      = (state_reg == RESP);
  assign sched.rsp_id         = rsp_id_reg;
  assign sched.rsp_c          = result_reg.c;
  assign sched.rsp_borrow_out = result_reg.borrow_out;
  assign sched.rsp_overflow   = result_reg.overflow;
  assign busy                 = (state_reg != IDLE);
endmodule
